irq_sequencer: RTL and testbench
================================

// Module: irq_sequencer
// PURPOSE
//  Interrupt controller that sequences the PC unit's interrupt path: captures NIRQ request lines, masks and
//  prioritises them, and drives irr/irr_dest/irr_ret into the PC unit so redirect and return happen at instruction
//  boundaries (enable_int). Single-level, non-nesting; return is via the RETIRQ opcode already decoded in the core.
// PARAMETERS
//  NIRQ   8   number of interrupt lines (2..32); line 0 = highest priority
//  IDW    3   width of irq_id, = clog2(NIRQ)
// PORTS
//  clk         in   1     core clock
//  rst         in   1     asynchronous, active-low reset (0 = reset)
//  irq_in      in   NIRQ  request lines, synchronous to clk, rising-edge sensitive
//  enable_int  in   1     instruction-retire strobe; the PC register updates on this edge
//  pc_next     in   32    PC the core would take without interrupt (PC_N with irr=0)
//  retirq      in   1     current instruction is RETIRQ (opcode 12'b001110011000)
//  cfg_we      in   1     config write strobe
//  cfg_sel     in   2     0=MASK 1=VBASE 2=PEND_CLR(W1C) 3=GIE
//  cfg_wdata   in   32    config write data
//  cfg_rdata   out  32    0=MASK 1=VBASE 2=PENDING 3={31'b0,GIE}; combinational on cfg_sel
//  irr         out  1     interrupt redirect request to PC unit
//  irr_dest    out  32    handler address = VBASE + {irq_id,2'b00}
//  irr_ret     out  32    saved return PC, used by PC unit on RETIRQ
//  in_service  out  1     a handler is executing
//  irq_id      out  IDW   index of the interrupt being requested/serviced
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; irr=0, in_service=0, irq_id=0, irr_ret=0; MASK=0, VBASE=0, GIE=0,
//   PENDING=0, edge history=0; irr_dest=0.
//  Capture: per line, irq_in & ~prev sets PENDING[i] at the clock edge. Set beats any same-cycle clear
//   (PEND_CLR write or take-clear). Levels held high do not re-pend.
//  Config: writes take effect at the clock edge; VBASE[1:0] forced to 0. MASK bit=1 enables the line.
//  Eligible = PENDING & MASK; winner = lowest set index (fixed priority).
//  FSM IDLE: if GIE & |eligible -> REQ next edge; irq_id <= winner (latched; later arrivals do not change it).
//  FSM REQ: irr=1, irr_dest from latched irq_id. On enable_int: irr_ret <= pc_next, PENDING[irq_id] cleared,
//   -> SERVICE (PC unit takes irr_dest on the same edge). irr is high only in REQ.
//   - GIE cleared or MASK[irq_id] cleared while in REQ before enable_int: request withdrawn, -> IDLE, PENDING kept.
//   - retirq while in REQ is ignored.
//  FSM SERVICE: in_service=1, irr=0; new pends accumulate. On enable_int & retirq -> IDLE (PC unit loads
//   irr_ret on that edge). irr_ret holds its value until the next take.
//  Latency: edge on irq_in at edge N -> PENDING at N -> REQ at N+1 -> redirect at first enable_int at/after N+1.
//  Back-to-back: IDLE after RETIRQ re-evaluates next cycle; a pending line is requested one cycle later.
//  Reset mid-operation: async return to reset state; a partially taken interrupt is lost.
// TESTING
//  1 Reset: rst=0 any state -> irr=0,in_service=0,cfg_rdata(GIE)=0,PENDING=0 immediately, no clk needed.
//  2 Basic: VBASE=0x100,MASK=0xFF,GIE=1; pulse irq_in[3]; pc_next=0x2C at enable_int -> irr=1,
//    irr_dest=0x10C; after edge irr_ret=0x2C,in_service=1,PENDING[3]=0; retirq+enable_int -> IDLE.
//  3 Priority: irq_in[5] and [2] same edge -> irq_id=2,irr_dest=VBASE+8; after RETIRQ line 5 requested,
//    irr_dest=VBASE+0x14.
//  4 Mask/withdraw: MASK=0x00, pulse irq_in[1] -> PENDING=0x02, irr stays 0; in REQ clear GIE -> IDLE, PENDING=0x02.
//  5 Collision: PEND_CLR write 0x01 same cycle as irq_in[0] rising -> PENDING[0]=1; no nesting: pulse
//    irq_in[0] during SERVICE -> irr stays 0 until RETIRQ retires.
//  6 Latch: in REQ for line 4 (enable_int held low), raise irq_in[0] -> irq_id stays 4, irr_dest unchanged.

Source files
------------

// File: rtl/irq_sequencer_if.sv
// Interrupt path bundle between the core/PC unit and irq_sequencer.
// Latency: n/a (wires only). Backpressure: none; enable_int paces redirect and return.
interface irq_sequencer_if #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
);
    logic [NIRQ-1:0] irq_in;
    logic            enable_int;
    logic [31:0]     pc_next;
    logic            retirq;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            irr;
    logic [31:0]     irr_dest;
    logic [31:0]     irr_ret;
    logic            in_service;
    logic [IDW-1:0]  irq_id;

    modport slave (
        input  irq_in, enable_int, pc_next, retirq, cfg_we, cfg_sel, cfg_wdata,
        output cfg_rdata, irr, irr_dest, irr_ret, in_service, irq_id
    );

    modport master (
        output irq_in, enable_int, pc_next, retirq, cfg_we, cfg_sel, cfg_wdata,
        input  cfg_rdata, irr, irr_dest, irr_ret, in_service, irq_id
    );
endinterface

// File: rtl/irq_sequencer.sv
// Single-level interrupt sequencer: edge capture, mask, fixed priority, redirect/return to the PC unit.
// Latency: irq edge pends at edge N, irr asserts at N+1; redirect on first enable_int from then on.
// Backpressure: request holds in REQ until enable_int retires an instruction; new edges keep pending.
module irq_sequencer #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    irq_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] prev_q, prev_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [31:0]     vbase_q, vbase_d;
    logic            gie_q, gie_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [31:0]     irr_ret_q, irr_ret_d;
    logic            irr_q, irr_d;
    logic            in_svc_q, in_svc_d;

    logic [NIRQ-1:0] elig;
    logic [NIRQ-1:0] clr_w1c;
    logic [NIRQ-1:0] take_clr;
    logic [IDW-1:0]  win_idx;
    logic            take;
    logic [31:0]     rdata;

    always_comb begin
        mask_d  = mask_q;
        vbase_d = vbase_q;
        gie_d   = gie_q;
        clr_w1c = '0;
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                2'd0:    mask_d  = bus.cfg_wdata[NIRQ-1:0];
                2'd1:    vbase_d = {bus.cfg_wdata[31:2], 2'b00};
                2'd2:    clr_w1c = bus.cfg_wdata[NIRQ-1:0];
                default: gie_d   = bus.cfg_wdata[0];
            endcase
        end
    end

    // Descending scan so the lowest eligible index is the last to win.
    always_comb begin
        elig    = pend_q & mask_q;
        win_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_idx = IDW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        irr_ret_d = irr_ret_q;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gie_q && (|elig)) begin
                    state_d  = REQ;
                    irq_id_d = win_idx;
                end
            end
            REQ: begin
                // irr was visible this cycle, so a retire wins over a same-edge withdraw.
                if (bus.enable_int) begin
                    take      = 1'b1;
                    irr_ret_d = bus.pc_next;
                    state_d   = SERVICE;
                end else if (!gie_d || !mask_d[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.enable_int && bus.retirq) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irr_d    = (state_d == REQ);
        in_svc_d = (state_d == SERVICE);
    end

    // Fresh rising edges override both clear sources in the same cycle.
    always_comb begin
        take_clr = '0;
        if (take) take_clr[irq_id_q] = 1'b1;
        prev_d = bus.irq_in;
        pend_d = (pend_q & ~clr_w1c & ~take_clr) | (bus.irq_in & ~prev_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            vbase_q   <= '0;
            gie_q     <= 1'b0;
            irq_id_q  <= '0;
            irr_ret_q <= '0;
            irr_q     <= 1'b0;
            in_svc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            vbase_q   <= vbase_d;
            gie_q     <= gie_d;
            irq_id_q  <= irq_id_d;
            irr_ret_q <= irr_ret_d;
            irr_q     <= irr_d;
            in_svc_q  <= in_svc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.cfg_sel)
            2'd0:    rdata[NIRQ-1:0] = mask_q;
            2'd1:    rdata = vbase_q;
            2'd2:    rdata[NIRQ-1:0] = pend_q;
            default: rdata[0] = gie_q;
        endcase
    end

    assign bus.cfg_rdata  = rdata;
    assign bus.irr        = irr_q;
    assign bus.in_service = in_svc_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.irr_ret    = irr_ret_q;
    assign bus.irr_dest   = vbase_q + {{(32 - IDW - 2){1'b0}}, irq_id_q, 2'b00};

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: reset, config, basic take/return, priority, mask, collision, latch.
module tb_irq_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_sequencer_if #(.NIRQ(8), .IDW(3)) bus ();

    irq_sequencer #(.NIRQ(8), .IDW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_wdata = data;
        cyc();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        bus.cfg_sel = sel;
        #1;
        v = bus.cfg_rdata;
    endtask

    task automatic pulse(input int line);
        bus.irq_in[line] = 1'b1;
        cyc();
        bus.irq_in[line] = 1'b0;
    endtask

    task automatic retire_normal(input logic [31:0] pc);
        bus.pc_next    = pc;
        bus.enable_int = 1'b1;
        cyc();
        bus.retirq     = 1'b1;
        cyc();
        bus.retirq     = 1'b0;
        bus.enable_int = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL reset_irr: got %0b want 0", bus.irr); end
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service: got %0b want 0", bus.in_service); end
        checks++; if (bus.irr_dest !== 32'h0) begin errors++; $display("FAIL reset_irr_dest: got %h want 0", bus.irr_dest); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_gie: got %h want 0", v); end
        rd(2'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", v); end
    endtask

    task automatic test_config();
        logic [31:0] v;
        cfg_write(2'd1, 32'h0000_0203);
        rd(2'd1, v);
        checks++; if (v !== 32'h0000_0200) begin errors++; $display("FAIL cfg_vbase_align: got %h want 00000200", v); end
        cfg_write(2'd0, 32'h0000_00A5);
        rd(2'd0, v);
        checks++; if (v !== 32'h0000_00A5) begin errors++; $display("FAIL cfg_mask: got %h want 000000a5", v); end
        cfg_write(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL cfg_gie: got %h want 1", v); end
        cfg_write(2'd3, 32'h0);
    endtask

    task automatic test_basic();
        logic [31:0] v;
        cfg_write(2'd1, 32'h100);
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd3, 32'h1);
        pulse(3);
        rd(2'd2, v);
        checks++; if (v !== 32'h08) begin errors++; $display("FAIL basic_pend: got %h want 08", v); end
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL basic_irr_early: got %0b want 0", bus.irr); end
        cyc();
        checks++; if (bus.irr !== 1'b1) begin errors++; $display("FAIL basic_irr: got %0b want 1", bus.irr); end
        checks++; if (bus.irr_dest !== 32'h10C) begin errors++; $display("FAIL basic_dest: got %h want 0000010c", bus.irr_dest); end
        checks++; if (bus.irq_id !== 3'd3) begin errors++; $display("FAIL basic_id: got %0d want 3", bus.irq_id); end
        bus.pc_next    = 32'h2C;
        bus.enable_int = 1'b1;
        cyc();
        bus.enable_int = 1'b0;
        checks++; if (bus.irr_ret !== 32'h2C) begin errors++; $display("FAIL basic_ret: got %h want 0000002c", bus.irr_ret); end
        checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL basic_svc: got %0b want 1", bus.in_service); end
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL basic_irr_svc: got %0b want 0", bus.irr); end
        rd(2'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL basic_pend_clr: got %h want 0", v); end
        bus.pc_next    = 32'h99;
        bus.retirq     = 1'b1;
        bus.enable_int = 1'b1;
        cyc();
        bus.retirq     = 1'b0;
        bus.enable_int = 1'b0;
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL basic_return: got %0b want 0", bus.in_service); end
        checks++; if (bus.irr_ret !== 32'h2C) begin errors++; $display("FAIL basic_ret_hold: got %h want 0000002c", bus.irr_ret); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        bus.irq_in = 8'h24;
        cyc();
        bus.irq_in = 8'h00;
        cyc();
        checks++; if (bus.irq_id !== 3'd2) begin errors++; $display("FAIL prio_id: got %0d want 2", bus.irq_id); end
        checks++; if (bus.irr_dest !== 32'h108) begin errors++; $display("FAIL prio_dest: got %h want 00000108", bus.irr_dest); end
        retire_normal(32'h40);
        rd(2'd2, v);
        checks++; if (v !== 32'h20) begin errors++; $display("FAIL prio_pend: got %h want 20", v); end
        cyc();
        checks++; if (bus.irr !== 1'b1) begin errors++; $display("FAIL prio_b2b_irr: got %0b want 1", bus.irr); end
        checks++; if (bus.irr_dest !== 32'h114) begin errors++; $display("FAIL prio_b2b_dest: got %h want 00000114", bus.irr_dest); end
        retire_normal(32'h44);
    endtask

    task automatic test_mask_withdraw();
        logic [31:0] v;
        cfg_write(2'd0, 32'h00);
        pulse(1);
        cyc();
        cyc();
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL mask_irr: got %0b want 0", bus.irr); end
        rd(2'd2, v);
        checks++; if (v !== 32'h02) begin errors++; $display("FAIL mask_pend: got %h want 02", v); end
        cfg_write(2'd0, 32'hFF);
        cyc();
        checks++; if (bus.irr !== 1'b1) begin errors++; $display("FAIL unmask_irr: got %0b want 1", bus.irr); end
        cfg_write(2'd3, 32'h0);
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL withdraw_irr: got %0b want 0", bus.irr); end
        checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL withdraw_svc: got %0b want 0", bus.in_service); end
        rd(2'd2, v);
        checks++; if (v !== 32'h02) begin errors++; $display("FAIL withdraw_pend: got %h want 02", v); end
        cfg_write(2'd2, 32'h02);
        cfg_write(2'd3, 32'h1);
        rd(2'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL w1c_pend: got %h want 0", v); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus.irq_in[0] = 1'b1;
        cfg_write(2'd2, 32'h01);
        bus.irq_in[0] = 1'b0;
        rd(2'd2, v);
        checks++; if (v !== 32'h01) begin errors++; $display("FAIL coll_pend: got %h want 01", v); end
        cyc();
        checks++; if (bus.irr !== 1'b1 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL coll_req: got irr=%0b id=%0d want irr=1 id=0", bus.irr, bus.irq_id); end
        bus.enable_int = 1'b1;
        cyc();
        bus.enable_int = 1'b0;
        pulse(0);
        cyc();
        cyc();
        checks++; if (bus.irr !== 1'b0 || bus.in_service !== 1'b1) begin errors++; $display("FAIL nonest: got irr=%0b svc=%0b want irr=0 svc=1", bus.irr, bus.in_service); end
        bus.retirq     = 1'b1;
        bus.enable_int = 1'b1;
        cyc();
        bus.retirq     = 1'b0;
        bus.enable_int = 1'b0;
        checks++; if (bus.irr !== 1'b0) begin errors++; $display("FAIL nonest_ret_irr: got %0b want 0", bus.irr); end
        cyc();
        checks++; if (bus.irr !== 1'b1 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL nonest_rereq: got irr=%0b id=%0d want irr=1 id=0", bus.irr, bus.irq_id); end
        retire_normal(32'h50);
    endtask

    task automatic test_latch();
        logic [31:0] v;
        pulse(4);
        cyc();
        checks++; if (bus.irq_id !== 3'd4) begin errors++; $display("FAIL latch_id0: got %0d want 4", bus.irq_id); end
        bus.irq_in[0] = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.irq_id !== 3'd4) begin errors++; $display("FAIL latch_id: got %0d want 4", bus.irq_id); end
        checks++; if (bus.irr_dest !== 32'h110) begin errors++; $display("FAIL latch_dest: got %h want 00000110", bus.irr_dest); end
        rd(2'd2, v);
        checks++; if (v !== 32'h11) begin errors++; $display("FAIL latch_pend: got %h want 11", v); end
        bus.pc_next    = 32'h80;
        bus.retirq     = 1'b1;
        bus.enable_int = 1'b1;
        cyc();
        checks++; if (bus.in_service !== 1'b1 || bus.irr_ret !== 32'h80) begin errors++; $display("FAIL req_retirq: got svc=%0b ret=%h want svc=1 ret=00000080", bus.in_service, bus.irr_ret); end
        cyc();
        bus.retirq     = 1'b0;
        bus.enable_int = 1'b0;
        cyc();
        checks++; if (bus.irq_id !== 3'd0 || bus.irr_dest !== 32'h100) begin errors++; $display("FAIL latch_next: got id=%0d dest=%h want id=0 dest=00000100", bus.irq_id, bus.irr_dest); end
        retire_normal(32'h84);
        bus.irq_in[0] = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        pulse(3);
        cyc();
        checks++; if (bus.irr !== 1'b1) begin errors++; $display("FAIL arst_pre_irr: got %0b want 1", bus.irr); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.irr !== 1'b0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL arst_out: got irr=%0b svc=%0b want 0 0", bus.irr, bus.in_service); end
        checks++; if (bus.irr_ret !== 32'h0 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL arst_ret: got ret=%h id=%0d want 0 0", bus.irr_ret, bus.irq_id); end
        rd(2'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL arst_pend: got %h want 0", v); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL arst_gie: got %h want 0", v); end
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus.irq_in     = '0;
        bus.enable_int = 1'b0;
        bus.pc_next    = '0;
        bus.retirq     = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = 2'd0;
        bus.cfg_wdata  = '0;
        #2;
        test_reset();
        #8;
        rst = 1'b1;
        cyc();
        test_config();
        test_basic();
        test_priority();
        test_mask_withdraw();
        test_collision();
        test_latch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
